leds_cmd_encoder: RTL



---
 rtl/leds_pkg.sv | 27 ++
 rtl/leds_btn_debounce.sv | 71 +++++++
 rtl/leds_cmd_encoder.sv | 108 ++++++++++
 3 files changed

// File: rtl/leds_pkg.sv
// leds_pkg -- shared definitions for the LED command path.
//   Command encodings consumed by the Leds block (one-hot or none), the
//   encoder FSM state type, and a helper that picks the winning press.
//   No ports; imported by leds_cmd_encoder, leds_btn_debounce and Leds.
package leds_pkg;

  localparam logic [2:0] CMD_NONE = 3'b000;
  localparam logic [2:0] CMD_LED1 = 3'b001;
  localparam logic [2:0] CMD_LED2 = 3'b010;
  localparam logic [2:0] CMD_LED3 = 3'b100;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Lowest-index press wins; the remaining simultaneous presses are dropped.
  function automatic logic [2:0] lowest_press(input logic [2:0] press);
    logic [2:0] sel;
    sel = CMD_NONE;
    if (press[0])      sel = CMD_LED1;
    else if (press[1]) sel = CMD_LED2;
    else if (press[2]) sel = CMD_LED3;
    return sel;
  endfunction

endpackage

// File: rtl/leds_btn_debounce.sv
// leds_btn_debounce -- one push-button channel: 2-flop synchroniser,
// debounce filter and rising-edge detect.
//   Macro LEDS_CMD_DEBOUNCE_EN: when defined the debounce filter is built;
//   when undefined the accepted level is the synchroniser output directly.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous active-high reset
//   btn    in  raw asynchronous button level
//   press  out one-cycle pulse when the accepted level rises
module leds_btn_debounce
  import leds_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic sync_p0;
  logic sync_p1;
  logic level;
  logic level_d;

  // Stage p0/p1: metastability synchroniser
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

`ifdef LEDS_CMD_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Debounce stage: the level is accepted only after DEBOUNCE_CYCLES
  // consecutive cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_p1 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= sync_p1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign level = sync_p1;
`endif

  // Edge-detect stage: only rising accepted levels are commands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_d <= 1'b0;
    else       level_d <= level;
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/leds_cmd_encoder.sv
// leds_cmd_encoder -- turns debounced button presses into the one-hot LED
// command for the Leds block, with toggle-off and inactivity auto-release.
//   Macro LEDS_CMD_DEBOUNCE_EN selects the debounce filter inside
//   leds_btn_debounce (undefined: filter bypassed, 3-edge latency).
// Ports:
//   clk         in  50 MHz system clock, rising edge
//   reset       in  asynchronous active-high reset
//   btn[2:0]    in  raw push-buttons, btn[i] selects LED i+1
//   cmd[2:0]    out registered one-hot command, 000 = automatic mode
//   cmd_strobe  out one-cycle pulse in the cycle cmd takes a new value
//   active      out high while cmd is non-zero
module leds_cmd_encoder
  import leds_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 250_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] btn,
  output logic [2:0] cmd,
  output logic       cmd_strobe,
  output logic       active
);

  localparam bit TIMEOUT_EN = (HOLD_CYCLES > 0);
  localparam int TW = TIMEOUT_EN ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_EN ? HOLD_CYCLES - 1 : 0);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_EN ? HOLD_CYCLES : 0);

  logic [2:0]    press;
  logic [2:0]    sel;
  state_t        state, state_n;
  logic [2:0]    cmd_n;
  logic          strobe_n;
  logic [TW-1:0] timer, timer_n;

  for (genvar i = 0; i < 3; i++) begin : g_btn
    leds_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk  (clk),
      .reset(reset),
      .btn  (btn[i]),
      .press(press[i])
    );
  end

  always_comb begin
    state_n  = state;
    cmd_n    = cmd;
    strobe_n = 1'b0;
    timer_n  = timer;
    sel      = lowest_press(press);
    case (state)
      ST_IDLE: begin
        timer_n = '0;
        if (sel != CMD_NONE) begin
          state_n  = ST_ACTIVE;
          cmd_n    = sel;
          strobe_n = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // A press always beats a timeout landing in the same cycle
        if (sel != CMD_NONE) begin
          timer_n  = '0;
          strobe_n = 1'b1;
          if (sel == cmd) begin
            state_n = ST_IDLE;
            cmd_n   = CMD_NONE;
          end else begin
            cmd_n = sel;
          end
        end else if (TIMEOUT_EN && timer == T_LAST) begin
          state_n  = ST_IDLE;
          cmd_n    = CMD_NONE;
          strobe_n = 1'b1;
          timer_n  = '0;
        end else if (TIMEOUT_EN && timer != T_MAX) begin
          timer_n = timer + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cmd_n   = CMD_NONE;
        timer_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cmd        <= CMD_NONE;
      cmd_strobe <= 1'b0;
      timer      <= '0;
    end else begin
      state      <= state_n;
      cmd        <= cmd_n;
      cmd_strobe <= strobe_n;
      timer      <= timer_n;
    end
  end

  assign active = (cmd != CMD_NONE);

endmodule
